// File: rtl/udp_tx_arbiter.sv
// -----------------------------------------------------------------------------
// udp_tx_arbiter
//
// Shares one outgoing UDP header stream and one payload stream among NUM_SRC
// transmit sources, granting them in round-robin order. A grant covers one
// complete packet: first the 64-bit header beat (with its 16-bit UDP port in
// tdest), then the payload frame up to and including its tlast beat. The grant
// is released only when that tlast beat is accepted, so headers and payloads
// from different sources never interleave.
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   s_udphdr_*           per-source header beats; source i at [64*i +: 64],
//                        tdest at [16*i +: 16], valid/ready at bit i
//   s_udpdata_*          per-source payload; tdata at [PAYLOAD_WIDTH*i +: ..],
//                        tkeep at [PAYLOAD_WIDTH/8*i +: ..], tlast/valid/ready
//                        at bit i
//   m_udphdr_*           shared header output (tdata, tdest, valid, ready)
//   m_udpdata_*          shared payload output (tdata, tkeep, tlast, valid,
//                        ready)
//   grant_active         one-cycle pulse on bit i in the cycle after source
//                        i's header is accepted (statistics)
//
// Timing: one arbitration cycle in IDLE, one header cycle, then the payload
// beats, giving N+2 cycles for an N-beat packet with no back-pressure. The
// master-side valids and the source-side readies are combinational
// passthroughs gated by the registered state and grant.
// -----------------------------------------------------------------------------
module udp_tx_arbiter #(
  parameter int NUM_SRC       = 2,
  parameter int PAYLOAD_WIDTH = 64
) (
  input  logic                               aclk,
  input  logic                               aresetn,

  input  logic [NUM_SRC*64-1:0]              s_udphdr_tdata,
  input  logic [NUM_SRC*16-1:0]              s_udphdr_tdest,
  input  logic [NUM_SRC-1:0]                 s_udphdr_tvalid,
  output logic [NUM_SRC-1:0]                 s_udphdr_tready,

  input  logic [NUM_SRC*PAYLOAD_WIDTH-1:0]   s_udpdata_tdata,
  input  logic [NUM_SRC*PAYLOAD_WIDTH/8-1:0] s_udpdata_tkeep,
  input  logic [NUM_SRC-1:0]                 s_udpdata_tlast,
  input  logic [NUM_SRC-1:0]                 s_udpdata_tvalid,
  output logic [NUM_SRC-1:0]                 s_udpdata_tready,

  output logic [63:0]                        m_udphdr_tdata,
  output logic [15:0]                        m_udphdr_tdest,
  output logic                               m_udphdr_tvalid,
  input  logic                               m_udphdr_tready,

  output logic [PAYLOAD_WIDTH-1:0]           m_udpdata_tdata,
  output logic [PAYLOAD_WIDTH/8-1:0]         m_udpdata_tkeep,
  output logic                               m_udpdata_tlast,
  output logic                               m_udpdata_tvalid,
  input  logic                               m_udpdata_tready,

  output logic [NUM_SRC-1:0]                 grant_active
);

  localparam int KEEP_W = PAYLOAD_WIDTH / 8;
  localparam int GW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t        state_r;
  logic [GW-1:0] grant_r;
  logic [GW-1:0] last_grant_r;
  logic [GW-1:0] next_grant_s;
  logic          any_req_s;
  logic          hdr_fire_s;
  logic          data_done_s;

  // One-hot vector with only bit idx set.
  function automatic logic [NUM_SRC-1:0] onehot(input logic [GW-1:0] idx);
    logic [NUM_SRC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: first requester after last_grant, wrapping modulo NUM_SRC.
  always_comb begin
    logic          found;
    logic          hit;
    logic [GW-1:0] idx;
    next_grant_s = last_grant_r;
    found        = 1'b0;
    hit          = 1'b0;
    idx          = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx          = GW'((int'(last_grant_r) + k) % NUM_SRC);
      hit          = !found && s_udphdr_tvalid[idx];
      next_grant_s = hit ? idx : next_grant_s;
      found        = found | hit;
    end
    any_req_s = found;
  end

  // Steer the granted source onto the master ports and its readies back.
  always_comb begin
    // Data fields always follow the grant; they are only meaningful with valid.
    m_udphdr_tdata   = s_udphdr_tdata[64*int'(grant_r) +: 64];
    m_udphdr_tdest   = s_udphdr_tdest[16*int'(grant_r) +: 16];
    m_udpdata_tdata  = s_udpdata_tdata[PAYLOAD_WIDTH*int'(grant_r) +: PAYLOAD_WIDTH];
    m_udpdata_tkeep  = s_udpdata_tkeep[KEEP_W*int'(grant_r) +: KEEP_W];
    m_udpdata_tlast  = s_udpdata_tlast[grant_r];
    m_udphdr_tvalid  = 1'b0;
    m_udpdata_tvalid = 1'b0;
    s_udphdr_tready  = '0;
    s_udpdata_tready = '0;
    case (state_r)
      ST_HDR: begin
        m_udphdr_tvalid          = s_udphdr_tvalid[grant_r];
        s_udphdr_tready[grant_r] = m_udphdr_tready;
      end
      ST_DATA: begin
        // Payload is held off until its header has gone out, so early payload
        // simply waits with ready low.
        m_udpdata_tvalid          = s_udpdata_tvalid[grant_r];
        s_udpdata_tready[grant_r] = m_udpdata_tready;
      end
      default: begin
        m_udphdr_tvalid  = 1'b0;
        m_udpdata_tvalid = 1'b0;
      end
    endcase
  end

  // Handshake qualifiers for the state machine.
  always_comb begin
    hdr_fire_s  = (state_r == ST_HDR) && m_udphdr_tvalid && m_udphdr_tready;
    data_done_s = (state_r == ST_DATA) && m_udpdata_tvalid && m_udpdata_tready
                  && m_udpdata_tlast;
  end

  // Packet-level grant FSM; the grant is held from arbitration until tlast.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r      <= ST_IDLE;
      grant_r      <= '0;
      // Pointing at the highest index gives source 0 first priority.
      last_grant_r <= GW'(NUM_SRC - 1);
      grant_active <= '0;
    end else begin
      grant_active <= '0;
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            grant_r <= next_grant_s;
            state_r <= ST_HDR;
          end
        end
        ST_HDR: begin
          // A source that drops tvalid here keeps the grant indefinitely.
          if (hdr_fire_s) begin
            grant_active <= onehot(grant_r);
            state_r      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (data_done_s) begin
            last_grant_r <= grant_r;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
Round-robin arbiter that shares one outgoing UDP header/payload stream pair among NUM_SRC transmit sources. Each source presents a 64-bit header beat with a 16-bit tdest (UDP port), then a payload frame terminated by tlast. The block grants one source at a time and passes its header and then its complete payload frame to the shared UDP transmit path. It holds the grant until the payload tlast handshake, so headers and payloads never interleave between sources.

Parameters:
NUM_SRC, 2, number of requesting sources (1 is legal).
PAYLOAD_WIDTH, 64, payload tdata width in bits; tkeep width is PAYLOAD_WIDTH/8.

Ports:
aclk  input  1  clock
aresetn  input  1  asynchronous active-low reset
s_udphdr_tdata  input  NUM_SRC*64  per-source header beat; source i occupies [64*i +: 64]
s_udphdr_tdest  input  NUM_SRC*16  per-source UDP port, travels with the header
s_udphdr_tvalid  input  NUM_SRC  per-source header valid
s_udphdr_tready  output  NUM_SRC  per-source header ready
s_udpdata_tdata  input  NUM_SRC*PAYLOAD_WIDTH  per-source payload
s_udpdata_tkeep  input  NUM_SRC*PAYLOAD_WIDTH/8  per-source payload byte enables
s_udpdata_tlast  input  NUM_SRC  per-source end of frame
s_udpdata_tvalid  input  NUM_SRC  per-source payload valid
s_udpdata_tready  output  NUM_SRC  per-source payload ready
m_udphdr_tdata  output  64  granted header
m_udphdr_tdest  output  16  granted UDP port
m_udphdr_tvalid  output  1  header valid
m_udphdr_tready  input  1  header ready
m_udpdata_tdata  output  PAYLOAD_WIDTH  granted payload
m_udpdata_tkeep  output  PAYLOAD_WIDTH/8  granted byte enables
m_udpdata_tlast  output  1  granted end of frame
m_udpdata_tvalid  output  1  payload valid
m_udpdata_tready  input  1  payload ready
grant_active  output  NUM_SRC  one-cycle pulse on bit i when source i's header is accepted (statistics)

Behaviour:
- Reset (aresetn low, asynchronous): state=IDLE; grant index=0; last_grant=NUM_SRC-1, so source 0 has first priority. All m_*_tvalid=0, all s_*_tready=0, grant_active=0. Reset mid-packet abandons the frame; no partial output after deassertion.
- Grant index width is max(1, $clog2(NUM_SRC)).
- State IDLE: all readies and valids are 0. If any s_udphdr_tvalid bit is set, register grant = first requesting index scanning last_grant+1, last_grant+2, … with wrap modulo NUM_SRC, then go to HDR. With no requests, remain in IDLE.
- State HDR: combinational passthrough of the granted header. m_udphdr_tvalid=s_udphdr_tvalid[grant] and s_udphdr_tready[grant]=m_udphdr_tready. Other readies are 0 and all payload readies are 0. On handshake: grant_active[grant] pulses for the following cycle (registered), then go to DATA.
- State DATA: combinational passthrough of the granted payload (tdata/tkeep/tlast/tvalid to m_, m_udpdata_tready to s_udpdata_tready[grant]). All header readies are 0. On a valid&ready&tlast beat: last_grant<=grant, then go to IDLE.
- Header tdata/tdest pass through unmodified. m_ data outputs are don't-care when the matching valid is 0 (drive granted source's data).
- Best-case throughput is N+2 cycles per N-beat packet (one IDLE arbitration cycle, one header cycle, then N payload beats). Back-pressure on either master stalls without loss.
- A source that drops tvalid after being granted keeps the grant (no timeout). Payload presented before its header is accepted waits (ready=0).
- Fairness: with all sources requesting continuously, grants cycle 0,1,…,NUM_SRC-1,0. No source receives two packets while another is waiting.
- A single-beat payload (tlast on the first beat) is legal. Every payload has at least one beat.

Test Plan:
- Single source: src1 sends header tdest=0x1234, then 3 payload beats with tlast on beat 3 → m_udphdr_tdest=0x1234, 3 beats out in order; grant_active=2'b10 for one cycle; total 5 cycles with m_ readies held at 1.
- Contention: both sources request continuously with 2-beat packets after reset → grant order 0,1,0,1. Each packet occupies 4 cycles. No interleaving.
- Back-pressure: m_udpdata_tready toggles 1,0,1,0 during a 4-beat frame from src0 → every beat delivered exactly once. src1 header ready stays 0 until src0 tlast is accepted.
- Early payload: src0 payload valid asserted 3 cycles before its header valid → s_udpdata_tready[0]=0 until the header handshake. Payload follows the header with no loss.
- Reset mid-frame: assert aresetn low after beat 2 of 4 → all valids/readies go 0 immediately. After release, a new src1 request is granted, since last_grant=1 after reset and priority starts at src0 but only src1 requests.
- NUM_SRC=1 build: consecutive packets pass with a 1-cycle IDLE gap. grant_active[0] pulses once per packet.
